regfile_dump_checker: RTL and testbench

//  Hardware counterpart of the processor bench check. On a start pulse it reads GPRs 1..31

---
 rtl/regfile_dump_checker_pkg.sv | 28 ++
 rtl/regfile_dump_checker_if.sv | 26 ++
 rtl/regfile_dump_checker_bank.sv | 56 +++++
 rtl/regfile_dump_checker.sv | 186 ++++++++++++++++++
 tb/tb_regfile_dump_checker.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_dump_checker_pkg.sv
// Shared types and constants for the register-file dump checker: FSM encoding,
// dumped index range and the reset content of the expected bank.
package regfile_dump_checker_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 31;

    localparam logic [ADDR_W-1:0] FIRST_REG = 5'd1;
    localparam logic [ADDR_W-1:0] LAST_REG  = 5'd31;
    localparam logic [DATA_W-1:0] EXP_INIT  = 32'hcafebabe;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_SEND   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // Map a register index onto its slot in the expected bank (r1 lives in slot 0).
    function automatic reg_idx_t bank_slot(input reg_idx_t idx);
        return idx - FIRST_REG;
    endfunction

endpackage

// File: rtl/regfile_dump_checker_if.sv
// Valid/ready stream carrying one dumped register word {index, value, mismatch}.
interface regfile_dump_checker_if;
    import regfile_dump_checker_pkg::*;

    logic      out_valid;
    logic      out_ready;
    reg_idx_t  out_index;
    reg_data_t out_data;
    logic      out_mismatch;

    modport master (
        output out_valid,
        output out_index,
        output out_data,
        output out_mismatch,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_data,
        input  out_mismatch,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_checker_bank.sv
// Expected-value bank for r1..r31: one guarded write port, one combinational read port.
module expected_reg_bank
    import regfile_dump_checker_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      we,
    input  logic      busy,
    input  reg_idx_t  waddr,
    input  reg_data_t wdata,
    input  reg_idx_t  raddr,
    output reg_data_t rdata
);

    reg_data_t mem_q [NUM_REGS];
    reg_data_t mem_d [NUM_REGS];
    logic      wr_ok_s;
    reg_idx_t  wr_slot_s;
    reg_idx_t  rd_slot_s;

    // The compare set is frozen while a dump runs; r0 has no entry.
    assign wr_ok_s   = we && !busy && (waddr != 5'd0);
    assign wr_slot_s = bank_slot(waddr);
    assign rd_slot_s = bank_slot(raddr);

    // Next bank contents with the optional write applied.
    always_comb begin
        mem_d = mem_q;
        if (wr_ok_s) begin
            mem_d[wr_slot_s] = wdata;
        end else begin
            mem_d[wr_slot_s] = mem_q[wr_slot_s];
        end
    end

    // Bank storage, reinitialised to EXP_INIT on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= EXP_INIT;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read; index 0 is not stored and reads as the default.
    always_comb begin
        if (raddr != 5'd0) begin
            rdata = mem_q[rd_slot_s];
        end else begin
            rdata = EXP_INIT;
        end
    end

endmodule

// File: rtl/regfile_dump_checker.sv
// Debug self-test unit: reads GPRs r1..r31 through the debug port, compares them with
// the expected bank and streams {index, value, mismatch} out with pass/fail statistics.
module regfile_dump_checker
    import regfile_dump_checker_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   exp_we,
    input  reg_idx_t               exp_addr,
    input  reg_data_t              exp_data,
    output reg_idx_t               rf_raddr,
    input  reg_data_t              rf_rdata,
    regfile_dump_checker_if.master dout,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output reg_idx_t               fail_index,
    output logic [5:0]             fail_count
);

    state_e    state_q, state_d;
    reg_idx_t  idx_q, idx_d;
    reg_idx_t  rf_raddr_q, rf_raddr_d;
    logic      out_valid_q, out_valid_d;
    reg_idx_t  out_index_q, out_index_d;
    reg_data_t out_data_q, out_data_d;
    logic      out_mismatch_q, out_mismatch_d;
    logic      busy_q, busy_d;
    logic      done_q, done_d;
    logic      pass_q, pass_d;
    reg_idx_t  fail_index_q, fail_index_d;
    logic [5:0] fail_count_q, fail_count_d;

    reg_data_t exp_rdata_s;
    logic      mismatch_s;

    expected_reg_bank u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (exp_we),
        .busy  (busy_q),
        .waddr (exp_addr),
        .wdata (exp_data),
        .raddr (idx_q),
        .rdata (exp_rdata_s)
    );

    assign mismatch_s = (rf_rdata != exp_rdata_s);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: state_d = ST_SEND;
            ST_SEND: begin
                if (dout.out_ready) begin
                    state_d = (idx_q == LAST_REG) ? ST_FINISH : ST_READ;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values per state; everything holds by default.
    always_comb begin
        idx_d          = idx_q;
        rf_raddr_d     = rf_raddr_q;
        out_valid_d    = out_valid_q;
        out_index_d    = out_index_q;
        out_data_d     = out_data_q;
        out_mismatch_d = out_mismatch_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        pass_d         = pass_q;
        fail_index_d   = fail_index_q;
        fail_count_d   = fail_count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d        = FIRST_REG;
                    rf_raddr_d   = FIRST_REG;
                    busy_d       = 1'b1;
                    pass_d       = 1'b0;
                    fail_index_d = 5'd0;
                    fail_count_d = 6'd0;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_READ: begin
                out_valid_d    = 1'b1;
                out_index_d    = idx_q;
                out_data_d     = rf_rdata;
                out_mismatch_d = mismatch_s;
                if (mismatch_s) begin
                    fail_count_d = fail_count_q + 6'd1;
                    fail_index_d = (fail_count_q == 6'd0) ? idx_q : fail_index_q;
                end else begin
                    fail_count_d = fail_count_q;
                end
            end
            ST_SEND: begin
                if (dout.out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_REG) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d      = idx_q + 5'd1;
                        rf_raddr_d = idx_q + 5'd1;
                    end
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            ST_FINISH: begin
                busy_d = 1'b0;
                pass_d = (fail_count_q == 6'd0);
            end
            default: begin
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Output, counter and statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q          <= FIRST_REG;
            rf_raddr_q     <= 5'd0;
            out_valid_q    <= 1'b0;
            out_index_q    <= 5'd0;
            out_data_q     <= 32'd0;
            out_mismatch_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_index_q   <= 5'd0;
            fail_count_q   <= 6'd0;
        end else begin
            idx_q          <= idx_d;
            rf_raddr_q     <= rf_raddr_d;
            out_valid_q    <= out_valid_d;
            out_index_q    <= out_index_d;
            out_data_q     <= out_data_d;
            out_mismatch_q <= out_mismatch_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            fail_index_q   <= fail_index_d;
            fail_count_q   <= fail_count_d;
        end
    end

    assign rf_raddr          = rf_raddr_q;
    assign dout.out_valid    = out_valid_q;
    assign dout.out_index    = out_index_q;
    assign dout.out_data     = out_data_q;
    assign dout.out_mismatch = out_mismatch_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign fail_index        = fail_index_q;
    assign fail_count        = fail_count_q;

endmodule

// File: tb/tb_regfile_dump_checker.sv
// Directed bench for regfile_dump_checker: table of full dumps plus hand-written
// sequences for busy-time interference, mid-dump reset and a last-register mismatch.
module tb_regfile_dump_checker;
    import regfile_dump_checker_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        busy, done, pass;
    logic [4:0]  fail_index;
    logic [5:0]  fail_count;
    logic [31:0] rf_mem [32];

    int total = 0;
    int bad   = 0;

    regfile_dump_checker_if dif ();

    regfile_dump_checker dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .exp_we     (exp_we),
        .exp_addr   (exp_addr),
        .exp_data   (exp_data),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .dout       (dif),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_index (fail_index),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    assign rf_rdata = rf_mem[rf_raddr];

    typedef struct {
        int          w0a;
        logic [31:0] w0d;
        int          w1a;
        logic [31:0] w1d;
        int          stall_idx;
        int          stall_n;
        logic [31:0] mask;
        int          done_c;
        logic        pass;
        int          fidx;
        int          fcnt;
    } vec_t;

    vec_t tbl [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    task automatic bank_wr(input int a, input logic [31:0] d);
        @(negedge clk);
        exp_we   = 1'b1;
        exp_addr = 5'(a);
        exp_data = d;
        @(negedge clk);
        exp_we   = 1'b0;
    endtask

    // One complete dump; inj_cyc >= 0 pulses start and a bank write to r3 mid-dump.
    task automatic run_dump(input string nm, input int stall_idx, input int stall_n,
                            input int inj_cyc, input logic [31:0] mask, input int done_c,
                            input logic exp_pass, input int fidx, input int fcnt);
        int cyc, nxt, stall_left, words, done_cnt, done_at;
        nxt = 1; stall_left = stall_n; words = 0; done_cnt = 0; done_at = -1; cyc = 0;
        @(negedge clk);
        dif.out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < 200 && !(done_cnt > 0 && cyc >= done_at + 2)) begin
            @(negedge clk);
            cyc++;
            start  = 1'b0;
            exp_we = 1'b0;
            if (cyc == inj_cyc) begin
                start    = 1'b1;
                exp_we   = 1'b1;
                exp_addr = 5'd3;
                exp_data = 32'hdeadbeef;
            end
            if (cyc == 1) begin
                chk({nm, " busy@1"}, 32'(busy), 32'd1);
                chk({nm, " pass_clr@1"}, 32'(pass), 32'd0);
                chk({nm, " fcnt_clr@1"}, 32'(fail_count), 32'd0);
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (dif.out_valid) begin
                chk({nm, " index"}, 32'(dif.out_index), 32'(nxt));
                chk({nm, " data"}, dif.out_data, rf_mem[nxt[4:0]]);
                chk({nm, " mismatch"}, 32'(dif.out_mismatch), 32'(mask[nxt[4:0]]));
                if (stall_left > 0 && nxt == stall_idx) begin
                    dif.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    dif.out_ready = 1'b1;
                    nxt++;
                    words++;
                end
            end else begin
                dif.out_ready = 1'b1;
            end
        end
        start  = 1'b0;
        exp_we = 1'b0;
        chk({nm, " words"}, 32'(words), 32'd31);
        chk({nm, " done_pulses"}, 32'(done_cnt), 32'd1);
        chk({nm, " done_cycle"}, 32'(done_at), 32'(done_c));
        chk({nm, " pass"}, 32'(pass), 32'(exp_pass));
        chk({nm, " fail_index"}, 32'(fail_index), 32'(fidx));
        chk({nm, " fail_count"}, 32'(fail_count), 32'(fcnt));
        chk({nm, " busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        reset = 1'b0; start = 1'b0; exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0;
        dif.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + 32'(i);

        tbl[0] = '{w0a: 0, w0d: 32'h1234, w1a: 0, w1d: 32'h0, stall_idx: 0, stall_n: 0,
                   mask: 32'h0, done_c: 63, pass: 1'b1, fidx: 0, fcnt: 0};
        tbl[1] = '{w0a: 5, w0d: 32'h0, w1a: 9, w1d: 32'h1, stall_idx: 0, stall_n: 0,
                   mask: 32'h0000_0220, done_c: 63, pass: 1'b0, fidx: 5, fcnt: 2};
        tbl[2] = '{w0a: 5, w0d: 32'h105, w1a: 9, w1d: 32'h109, stall_idx: 7, stall_n: 3,
                   mask: 32'h0, done_c: 66, pass: 1'b1, fidx: 0, fcnt: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 32'(dif.out_valid), 32'd0);
        chk("rst out_index", 32'(dif.out_index), 32'd0);
        chk("rst out_data", dif.out_data, 32'd0);
        chk("rst out_mismatch", 32'(dif.out_mismatch), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst pass", 32'(pass), 32'd0);
        chk("rst fail_index", 32'(fail_index), 32'd0);
        chk("rst fail_count", 32'(fail_count), 32'd0);
        chk("rst rf_raddr", 32'(rf_raddr), 32'd0);
        reset = 1'b1;

        for (int i = 1; i < 32; i++) bank_wr(i, 32'h100 + 32'(i));

        for (int t = 0; t < 3; t++) begin
            bank_wr(tbl[t].w0a, tbl[t].w0d);
            bank_wr(tbl[t].w1a, tbl[t].w1d);
            run_dump($sformatf("vec%0d", t), tbl[t].stall_idx, tbl[t].stall_n, -1,
                     tbl[t].mask, tbl[t].done_c, tbl[t].pass, tbl[t].fidx, tbl[t].fcnt);
        end

        // Restart and r3 write while busy, then an address-0 write while idle.
        run_dump("busy_inj", 0, 0, 10, 32'h0, 63, 1'b1, 0, 0);
        bank_wr(0, 32'h12345678);
        run_dump("after_inj", 0, 0, -1, 32'h0, 63, 1'b1, 0, 0);

        // Reset while index 12 is being offered.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            @(negedge clk);
            if (dif.out_valid && dif.out_index == 5'd12) seen = 1;
        end
        chk("abort reach12", 32'(seen), 32'd1);
        dif.out_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort out_valid", 32'(dif.out_valid), 32'd0);
        chk("abort out_index", 32'(dif.out_index), 32'd0);
        chk("abort out_data", dif.out_data, 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort rf_raddr", 32'(rf_raddr), 32'd0);
        chk("abort fail_count", 32'(fail_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dif.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("abort no_done", 32'(done), 32'd0);
        end
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hcafebabe;
        run_dump("post_reset", 0, 0, -1, 32'h0, 63, 1'b1, 0, 0);

        // Only r31 differs from the default bank.
        rf_mem[31] = 32'h0;
        run_dump("r31_bad", 0, 0, -1, 32'h8000_0000, 63, 1'b0, 31, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
